// File: rtl/fluxo_dados_genius_param_pkg.sv
// Shared constants and helpers for the sequence-memory game datapath
// and its control unit.
package fluxo_dados_genius_param_pkg;

  // Default game geometry, also used by unidade_controle.
  localparam int NCHAVES_DEF = 4;
  localparam int DEPTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 5000;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fluxo_dados_genius_param_contador.sv
// Modulo-M up counter with sync clear, count enable, and
// terminal (M-1) and half-way (M/2) decodes.
module contador_param
  import fluxo_dados_genius_param_pkg::*;
#(
  parameter int M = 16,
  localparam int W = clog2(M)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_zera,
  input  logic         i_conta,
  output logic [W-1:0] o_q,
  output logic         o_fim,
  output logic         o_meio
);

  localparam logic [W-1:0] LAST = W'(M - 1);
  localparam logic [W-1:0] MID  = W'(M / 2);

  logic [W-1:0] r_q;

  // Count register: clear wins over count, wraps from M-1 back to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_zera) begin
      r_q <= '0;
    end else if (i_conta) begin
      r_q <= (r_q == LAST) ? '0 : r_q + W'(1);
    end
  end

  assign o_q    = r_q;
  assign o_fim  = (r_q == LAST);
  assign o_meio = (r_q == MID);

endmodule

// File: rtl/fluxo_dados_genius_param.sv
// Datapath of the sequence-memory game: address/round/timer counters,
// played-key register, recordable sequence RAM, compare logic and a
// key-press edge detector. Sequencing comes from unidade_controle.
// RAM power-up contents are undefined; the controller records a
// sequence before it is played back.
module fluxo_dados_genius_param
  import fluxo_dados_genius_param_pkg::*;
#(
  parameter int NCHAVES = NCHAVES_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int AW     = clog2(DEPTH),
  localparam int TW     = clog2(TIMEOUT)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zeraE,
  input  logic               contaE,
  input  logic               zeraRod,
  input  logic               contaRod,
  input  logic               zeraT,
  input  logic               contaT,
  input  logic               zeraR,
  input  logic               registraR,
  input  logic               escreveM,
  input  logic [NCHAVES-1:0] chaves,
  output logic               fimE,
  output logic               fimRod,
  output logic               fimT,
  output logic               meioT,
  output logic               igual,
  output logic               enderecoIgualRodada,
  output logic               jogada_valida,
  output logic               jogada_feita,
  output logic               db_tem_jogada,
  output logic [AW-1:0]      db_contagem,
  output logic [AW-1:0]      db_rodada,
  output logic [NCHAVES-1:0] db_memoria,
  output logic [NCHAVES-1:0] db_jogada
);

  logic [AW-1:0]      w_endereco;
  logic [AW-1:0]      w_rodada;
  logic [TW-1:0]      w_timer_unused;
  logic               w_meioE_unused;
  logic               w_meioRod_unused;
  logic [NCHAVES-1:0] w_dado_mem;
  logic               w_tem_jogada;

  logic [NCHAVES-1:0] r_jogada;
  logic               r_hist;
  logic [NCHAVES-1:0] r_mem [DEPTH];

  contador_param #(.M(DEPTH)) u_cont_endereco (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_zera  (zeraE),
    .i_conta (contaE),
    .o_q     (w_endereco),
    .o_fim   (fimE),
    .o_meio  (w_meioE_unused)
  );

  contador_param #(.M(DEPTH)) u_cont_rodada (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_zera  (zeraRod),
    .i_conta (contaRod),
    .o_q     (w_rodada),
    .o_fim   (fimRod),
    .o_meio  (w_meioRod_unused)
  );

  contador_param #(.M(TIMEOUT)) u_cont_timer (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_zera  (zeraT),
    .i_conta (contaT),
    .o_q     (w_timer_unused),
    .o_fim   (fimT),
    .o_meio  (meioT)
  );

  // Played-key register: clear wins over load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_jogada <= '0;
    end else if (zeraR) begin
      r_jogada <= '0;
    end else if (registraR) begin
      r_jogada <= chaves;
    end
  end

  // Sequence RAM write port; uses the current (pre-edge) register
  // value and address, so same-cycle load/count see the old values.
  always_ff @(posedge clock) begin
    if (escreveM) begin
      r_mem[w_endereco] <= r_jogada;
    end
  end

  assign w_dado_mem   = r_mem[w_endereco];
  assign w_tem_jogada = |chaves;

  // Key-activity history for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hist <= 1'b0;
    end else begin
      r_hist <= w_tem_jogada;
    end
  end

  // Reset gates the pulse so nothing is reported while held in reset;
  // a key held across release still yields one pulse right after.
  assign jogada_feita = reset & w_tem_jogada & ~r_hist;

  assign jogada_valida       = (chaves != '0) &&
                               ((chaves & (chaves - NCHAVES'(1))) == '0);
  assign igual               = (w_dado_mem == r_jogada);
  assign enderecoIgualRodada = (w_endereco == w_rodada);
  assign db_tem_jogada       = w_tem_jogada;
  assign db_contagem         = w_endereco;
  assign db_rodada           = w_rodada;
  assign db_memoria          = w_dado_mem;
  assign db_jogada           = r_jogada;

endmodule
